manchester_encoder: RTL and testbench

Transmit-side counterpart of the oversampled Manchester receive path. It accepts bytes on a valid/ready stream, frames them with a preamble, Manchester-encodes them MSB-first and drives one line bit per aclk cycle. Each half-bit is held for HALF_BIT_CYCLES cycles, which sets the oversampling ratio seen at the far-end receiver. Bit encoding: a '1' is sent as low then high, and a '0' as high then low, so the second half equals the data bit.

---
 rtl/manchester_pkg.sv | 28 ++
 rtl/manchester_bit_timer.sv | 70 +++++++
 rtl/manchester_encoder.sv | 173 +++++++++++++++++
 tb/tb_manchester_encoder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/manchester_pkg.sv
// Shared Manchester line-coding definitions.
// Used by the transmit path (manchester_encoder) and by the receive path.
//   manch_state_e         : transmit FSM states
//   MANCH_ONE_FIRST_HALF  : line level of the first half-bit of a '1'
//   MANCH_HALF_BIT_CYCLES : default clock cycles per half-bit
//   manch_half()          : line level for a data bit in a given half
package manchester_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StData,
        StGap
    } manch_state_e;

    // A '1' is sent low-then-high, so the second half always equals the data bit.
    localparam logic MANCH_ONE_FIRST_HALF = 1'b0;

    localparam int unsigned MANCH_HALF_BIT_CYCLES = 4;

    function automatic logic manch_half(input logic data_bit, input logic second_half);
        if (second_half) begin
            return data_bit;
        end
        return data_bit ? MANCH_ONE_FIRST_HALF : ~MANCH_ONE_FIRST_HALF;
    endfunction

endpackage

// File: rtl/manchester_bit_timer.sv
// Half-bit / bit timing for the Manchester transmitter.
// Ports:
//   aclk, areset : clock, asynchronous active-high reset
//   en           : count enable; while low all counters are held at zero
//   bits_total   : number of bits in the current section (preamble, byte or gap)
//   second_half  : phase flag, high during the second half of a bit
//   bit_end      : last cycle of the second half-bit
//   bit_last     : bit_end of the final bit of the section (terminal count)
//   bit_cnt      : index of the current bit within the section
module manchester_bit_timer #(
    parameter int unsigned HALF_BIT_CYCLES = 4,
    parameter int unsigned BIT_CNT_W       = 5
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 en,
    input  logic [BIT_CNT_W-1:0] bits_total,
    output logic                 second_half,
    output logic                 bit_end,
    output logic                 bit_last,
    output logic [BIT_CNT_W-1:0] bit_cnt
);

    localparam int unsigned HalfW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam logic [HalfW-1:0] HalfMax = HalfW'(HALF_BIT_CYCLES - 1);

    logic [HalfW-1:0]     half_cnt_q, half_cnt_d;
    logic                 phase_q, phase_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 half_end;

    assign half_end    = en && (half_cnt_q == HalfMax);
    assign bit_end     = half_end && phase_q;
    assign bit_last    = bit_end && (bit_cnt_q == (bits_total - BIT_CNT_W'(1)));
    assign second_half = phase_q;
    assign bit_cnt     = bit_cnt_q;

    always_comb begin
        half_cnt_d = half_cnt_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        if (!en) begin
            half_cnt_d = '0;
            phase_d    = 1'b0;
            bit_cnt_d  = '0;
        end else if (half_end) begin
            half_cnt_d = '0;
            phase_d    = ~phase_q;
            // Wrap at terminal count so the next section starts at bit 0.
            if (bit_end) begin
                bit_cnt_d = bit_last ? '0 : bit_cnt_q + BIT_CNT_W'(1);
            end
        end else begin
            half_cnt_d = half_cnt_q + HalfW'(1);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            half_cnt_q <= '0;
            phase_q    <= 1'b0;
            bit_cnt_q  <= '0;
        end else begin
            half_cnt_q <= half_cnt_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/manchester_encoder.sv
// Manchester transmitter: frames bytes from a valid/ready stream with an
// alternating preamble, encodes them MSB-first and drives one line bit per cycle.
// Ports:
//   aclk, areset       : clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tready : byte input stream (one-byte holding register)
//   tx_bit             : registered line output
//   tx_en              : registered driver enable, high during preamble and data
//   busy               : FSM not idle
//   underrun           : one-cycle pulse when a non-final byte ends with no successor
module manchester_encoder
    import manchester_pkg::*;
#(
    parameter int unsigned HALF_BIT_CYCLES = MANCH_HALF_BIT_CYCLES,
    parameter int unsigned PREAMBLE_BITS   = 16,
    parameter int unsigned GAP_BITS        = 4,
    parameter logic        IDLE_LEVEL      = 1'b0
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    input  logic       s_tlast,
    output logic       s_tready,
    output logic       tx_bit,
    output logic       tx_en,
    output logic       busy,
    output logic       underrun
);

    localparam int unsigned MaxPg   = (PREAMBLE_BITS > GAP_BITS) ? PREAMBLE_BITS : GAP_BITS;
    localparam int unsigned MaxBits = (MaxPg > 8) ? MaxPg : 8;
    localparam int unsigned BitCntW = $clog2(MaxBits + 1);

    manch_state_e state_q, state_d;

    logic         hold_valid_q, hold_valid_d;
    logic [7:0]   hold_data_q, hold_data_d;
    logic         hold_last_q, hold_last_d;
    logic [7:0]   shift_q, shift_d;
    logic         last_q, last_d;
    logic         tx_bit_q, tx_bit_d;
    logic         tx_en_q, tx_en_d;
    logic         underrun_q, underrun_d;

    logic               take;
    logic               load;
    logic               timer_en;
    logic [BitCntW-1:0] bits_total;
    logic               second_half;
    logic               bit_end;
    logic               bit_last;
    logic [BitCntW-1:0] bit_cnt;
    logic               pre_bit;

    assign s_tready = !hold_valid_q;
    assign take     = s_tvalid && !hold_valid_q;
    assign timer_en = (state_q != StIdle);
    // Preamble alternates 1,0,1,0,... starting from bit 0.
    assign pre_bit  = ((bit_cnt & BitCntW'(1)) == '0);

    manchester_bit_timer #(
        .HALF_BIT_CYCLES(HALF_BIT_CYCLES),
        .BIT_CNT_W      (BitCntW)
    ) u_bit_timer (
        .aclk       (aclk),
        .areset     (areset),
        .en         (timer_en),
        .bits_total (bits_total),
        .second_half(second_half),
        .bit_end    (bit_end),
        .bit_last   (bit_last),
        .bit_cnt    (bit_cnt)
    );

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        shift_d    = shift_q;
        last_d     = last_q;
        bits_total = BitCntW'(8);
        tx_bit_d   = IDLE_LEVEL;
        tx_en_d    = 1'b0;
        underrun_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hold_valid_q) begin
                    state_d = StPreamble;
                end
            end
            StPreamble: begin
                bits_total = BitCntW'(PREAMBLE_BITS);
                tx_en_d    = 1'b1;
                tx_bit_d   = manch_half(pre_bit, second_half);
                // The first byte has been held since leaving idle.
                if (bit_last) begin
                    load    = 1'b1;
                    state_d = StData;
                end
            end
            StData: begin
                tx_en_d  = 1'b1;
                tx_bit_d = manch_half(shift_q[7], second_half);
                if (bit_last) begin
                    if (last_q) begin
                        state_d = StGap;
                    end else if (hold_valid_q) begin
                        load = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = StGap;
                    end
                end else if (bit_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                end
            end
            StGap: begin
                bits_total = BitCntW'(GAP_BITS);
                if (bit_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            shift_d = hold_data_q;
            last_d  = hold_last_q;
        end
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        if (load) begin
            hold_valid_d = 1'b0;
        end
        if (take) begin
            hold_valid_d = 1'b1;
            hold_data_d  = s_tdata;
            hold_last_d  = s_tlast;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= StIdle;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
            shift_q      <= '0;
            last_q       <= 1'b0;
            tx_bit_q     <= IDLE_LEVEL;
            tx_en_q      <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            shift_q      <= shift_d;
            last_q       <= last_d;
            tx_bit_q     <= tx_bit_d;
            tx_en_q      <= tx_en_d;
            underrun_q   <= underrun_d;
        end
    end

    assign tx_bit   = tx_bit_q;
    assign tx_en    = tx_en_q;
    assign underrun = underrun_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_manchester_encoder.sv
`timescale 1ns/1ps
module tb_manchester_encoder;

    localparam int unsigned H    = 2;
    localparam int unsigned PRE  = 2;
    localparam int unsigned GAP  = 1;
    localparam logic        IDLE = 1'b0;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_LOAD = 2'd1;
    localparam logic [1:0] TAG_BYTE = 2'd2;
    localparam logic [1:0] TAG_GAP  = 2'd3;

    logic       aclk = 1'b0;
    logic       areset;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tready;
    logic       tx_bit;
    logic       tx_en;
    logic       busy;
    logic       underrun;

    always #5 aclk = ~aclk;

    manchester_encoder #(
        .HALF_BIT_CYCLES(H),
        .PREAMBLE_BITS  (PRE),
        .GAP_BITS       (GAP),
        .IDLE_LEVEL     (IDLE)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .s_tdata (s_tdata),
        .s_tvalid(s_tvalid),
        .s_tlast (s_tlast),
        .s_tready(s_tready),
        .tx_bit  (tx_bit),
        .tx_en   (tx_en),
        .busy    (busy),
        .underrun(underrun)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired, got no event, expected one", name);
    endtask

    // Behavioural model: the line is a queue of per-cycle samples built from
    // the coding rules; tags mark where a byte is pulled from the holding slot.
    typedef struct packed {
        logic       en;
        logic       b;
        logic [1:0] tag;
    } samp_t;

    samp_t      line_q[$];
    logic       m_run, m_hold_v, m_hold_l, m_cur_last;
    logic [7:0] m_hold_d;
    logic       e_bit, e_en, e_und;

    task automatic model_reset();
        line_q.delete();
        m_run      = 1'b0;
        m_hold_v   = 1'b0;
        m_hold_l   = 1'b0;
        m_hold_d   = 8'h00;
        m_cur_last = 1'b0;
        e_bit      = IDLE;
        e_en       = 1'b0;
        e_und      = 1'b0;
    endtask

    task automatic push_bit(input logic b, input logic [1:0] tag);
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < int'(H); k++) begin
                samp_t s;
                s.en  = 1'b1;
                s.b   = (h == 0) ? ~b : b;
                s.tag = (h == 1 && k == int'(H) - 1) ? tag : TAG_NONE;
                line_q.push_back(s);
            end
        end
    endtask

    task automatic push_gap();
        for (int i = 0; i < int'(GAP * 2 * H); i++) begin
            samp_t s;
            s.en  = 1'b0;
            s.b   = IDLE;
            s.tag = (i == int'(GAP * 2 * H) - 1) ? TAG_GAP : TAG_NONE;
            line_q.push_back(s);
        end
    endtask

    task automatic push_byte();
        for (int i = 0; i < 8; i++) begin
            push_bit(m_hold_d[7-i], (i == 7) ? TAG_BYTE : TAG_NONE);
        end
        m_cur_last = m_hold_l;
        m_hold_v   = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic l);
        logic  ready;
        samp_t s;
        ready = !m_hold_v;
        e_und = 1'b0;
        if (!m_run) begin
            e_en  = 1'b0;
            e_bit = IDLE;
            if (m_hold_v) begin
                m_run = 1'b1;
                for (int i = 0; i < int'(PRE); i++) begin
                    push_bit((i % 2) == 0, (i == int'(PRE) - 1) ? TAG_LOAD : TAG_NONE);
                end
            end
        end else if (line_q.size() == 0) begin
            m_run = 1'b0;
            e_en  = 1'b0;
            e_bit = IDLE;
        end else begin
            s     = line_q.pop_front();
            e_en  = s.en;
            e_bit = s.b;
            case (s.tag)
                TAG_LOAD: push_byte();
                TAG_BYTE: begin
                    if (m_cur_last) begin
                        push_gap();
                    end else if (m_hold_v) begin
                        push_byte();
                    end else begin
                        e_und = 1'b1;
                        push_gap();
                    end
                end
                TAG_GAP: m_run = 1'b0;
                default: ;
            endcase
        end
        if (v && ready) begin
            m_hold_v = 1'b1;
            m_hold_d = d;
            m_hold_l = l;
        end
    endtask

    logic [63:0] cap;
    int          en_cnt;
    int          und_cnt;

    task automatic step(input logic v, input logic [7:0] d, input logic l);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        model_step(v, d, l);
        @(posedge aclk);
        #1;
        check("tx_bit", tx_bit, e_bit);
        check("tx_en", tx_en, e_en);
        check("underrun", underrun, e_und);
        check("s_tready", s_tready, !m_hold_v);
        check("busy", busy, m_run);
        if (tx_en) begin
            cap = {cap[62:0], tx_bit};
            en_cnt++;
        end
        if (underrun) und_cnt++;
    endtask

    task automatic step_idle();
        step(1'b0, 8'($urandom), 1'($urandom));
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 400 && !acc; i++) begin
            acc = s_tready;
            step(1'b1, d, l);
        end
        if (!acc) fail_now("send_accept");
        s_tvalid = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while ((m_run || m_hold_v) && i < 2000) begin
            step_idle();
            i++;
        end
        if (m_run || m_hold_v) fail_now("wait_done");
        step_idle();
    endtask

    task automatic measure_latency(output int lat);
        lat = 0;
        while (!tx_en && lat < 100) begin
            lat++;
            step_idle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pct;
        logic v;

        cap     = '0;
        en_cnt  = 0;
        und_cnt = 0;
        model_reset();

        // Reset held with a byte offered: nothing may be accepted.
        areset   = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 8'hFF;
        s_tlast  = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tx_bit", tx_bit, IDLE);
        check("rst_tx_en", tx_en, 1'b0);
        check("rst_s_tready", s_tready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        @(negedge aclk);
        s_tvalid = 1'b0;
        areset   = 1'b0;

        // Single byte 0xA5 with last.
        cap    = '0;
        en_cnt = 0;
        send(8'hA5, 1'b1);
        measure_latency(lat);
        check("first_edge_latency", 64'(lat), 64'd2);
        wait_done();
        check("a5_en_cycles", 64'(en_cnt), 64'd40);
        check("a5_line", {24'h0, cap[39:0]}, 64'h3C3C3CC3C3);

        // Back-to-back bytes: no gap inside the frame.
        en_cnt  = 0;
        und_cnt = 0;
        send(8'h00, 1'b0);
        send(8'hFF, 1'b1);
        wait_done();
        check("b2b_en_cycles", 64'(en_cnt), 64'd72);
        check("b2b_underrun", 64'(und_cnt), 64'd0);

        // Underrun: non-final byte with no successor.
        und_cnt = 0;
        en_cnt  = 0;
        send(8'h3C, 1'b0);
        wait_done();
        check("underrun_pulses", 64'(und_cnt), 64'd1);
        check("underrun_en_cycles", 64'(en_cnt), 64'd40);

        // Byte offered during the gap is accepted but waits for the gap.
        send(8'hA5, 1'b1);
        measure_latency(lat);
        for (int i = 0; i < 200 && tx_en; i++) step_idle();
        check("gap_s_tready", s_tready, 1'b1);
        check("gap_busy", busy, 1'b1);
        send(8'h5A, 1'b1);
        measure_latency(lat);
        check("gap_latency_gt2", 64'(lat > 2), 64'd1);
        wait_done();

        // Randomized traffic with varying offered load.
        for (int blk = 0; blk < 15; blk++) begin
            pct = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 30 : 90);
            for (int n = 0; n < 200; n++) begin
                v = ($urandom_range(0, 99) < pct);
                step(v, 8'($urandom), ($urandom_range(0, 3) == 0));
            end
        end
        wait_done();

        // Reset in the middle of a data byte.
        en_cnt  = 0;
        und_cnt = 0;
        send(8'h96, 1'b0);
        for (int i = 0; i < 200 && en_cnt <= int'(PRE * 2 * H) + 2; i++) step_idle();
        areset = 1'b1;
        #1;
        check("midrst_tx_bit", tx_bit, IDLE);
        check("midrst_tx_en", tx_en, 1'b0);
        check("midrst_underrun", underrun, 1'b0);
        check("midrst_busy", busy, 1'b0);
        @(posedge aclk);
        #1;
        check("midrst_underrun_edge", underrun, 1'b0);
        check("midrst_tx_en_edge", tx_en, 1'b0);
        @(negedge aclk);
        areset = 1'b0;
        model_reset();

        // Recovery frame after reset.
        en_cnt = 0;
        send(8'h42, 1'b1);
        wait_done();
        check("recover_en_cycles", 64'(en_cnt), 64'd40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
